// File: rtl/i2c_reg_responder.sv
// I2C register-target responder: 7-bit addressed writes/reads through an auto-incrementing
// 8-bit register pointer, with SCL/SDA oversampled, glitch-filtered and edge-detected on iCLK.
module i2c_reg_responder #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h39,
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       I2C_SCLK,
    inout  wire        I2C_SDAT,
    output logic [7:0] oREG_ADDR,
    output logic [7:0] oWR_DATA,
    output logic       oWR_EN,
    output logic       oRD_EN,
    input  logic [7:0] iRD_DATA,
    output logic       oBUSY
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
    } state_t;

    localparam logic [3:0] FILT_MAX = 4'(FILTER_LEN - 1);

    logic [1:0] scl_s_q, scl_s_d, sda_s_q, sda_s_d;
    logic [3:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
    logic       scl_f_q, scl_f_d, sda_f_q, sda_f_d;
    logic       scl_p_q, scl_p_d, sda_p_q, sda_p_d;

    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] ptr_q, ptr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       wr_en_q, wr_en_d;
    logic       rd_en_q, rd_en_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic       rw_q, rw_d;

    logic       scl_rise, scl_fall, sda_rise, sda_fall, start_c, stop_c;
    logic [7:0] byte_in;

    always_comb begin
        scl_s_d   = {scl_s_q[0], I2C_SCLK};
        sda_s_d   = {sda_s_q[0], I2C_SDAT};
        scl_f_d   = scl_f_q;
        sda_f_d   = sda_f_q;
        scl_cnt_d = '0;
        sda_cnt_d = '0;
        // a filtered line only follows the synchronized one after FILTER_LEN differing samples
        if (scl_s_q[1] != scl_f_q) begin
            if (scl_cnt_q == FILT_MAX) scl_f_d = scl_s_q[1];
            else                       scl_cnt_d = scl_cnt_q + 4'd1;
        end
        if (sda_s_q[1] != sda_f_q) begin
            if (sda_cnt_q == FILT_MAX) sda_f_d = sda_s_q[1];
            else                       sda_cnt_d = sda_cnt_q + 4'd1;
        end
        scl_p_d = scl_f_q;
        sda_p_d = sda_f_q;
    end

    assign scl_rise = scl_f_q & ~scl_p_q;
    assign scl_fall = ~scl_f_q & scl_p_q;
    assign sda_rise = sda_f_q & ~sda_p_q;
    assign sda_fall = ~sda_f_q & sda_p_q;
    assign start_c  = sda_fall & scl_f_q;
    assign stop_c   = sda_rise & scl_f_q;
    assign byte_in  = {shift_q[6:0], sda_f_q};

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        ptr_d     = ptr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        rw_d      = rw_q;

        if (wr_en_q) ptr_d = ptr_q + 8'd1;
        if (rd_en_q) begin
            tx_d     = iRD_DATA;
            sda_oe_d = ~iRD_DATA[7];
        end

        if (start_c) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else if (stop_c) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                ADDR, SUB, WDATA: begin
                    if (scl_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            if (state_q == ADDR) begin
                                if (byte_in[7:1] == SLAVE_ADDR) begin
                                    state_d = ADDR_ACK;
                                    rw_d    = byte_in[0];
                                    busy_d  = 1'b1;
                                end else begin
                                    state_d = IDLE;
                                    busy_d  = 1'b0;
                                end
                            end else if (state_q == SUB) begin
                                ptr_d   = byte_in;
                                state_d = SUB_ACK;
                            end else begin
                                wr_data_d = byte_in;
                                wr_en_d   = 1'b1;
                                state_d   = WDATA_ACK;
                            end
                        end
                    end
                end
                ADDR_ACK, SUB_ACK, WDATA_ACK: begin
                    // first falling edge starts the ACK, the next one ends it
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            if (state_q == ADDR_ACK && rw_q) begin
                                rd_en_d = 1'b1;
                                state_d = RDATA;
                            end else if (state_q == ADDR_ACK) begin
                                state_d = SUB;
                            end else begin
                                state_d = WDATA;
                            end
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            ptr_d    = ptr_q + 8'd1;
                            state_d  = RDATA_ACK;
                        end else begin
                            tx_d     = tx_q << 1;
                            sda_oe_d = ~tx_q[6];
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise) begin
                        if (sda_f_q) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end else begin
                            bit_cnt_d = 4'd9;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd9) begin
                        rd_en_d   = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = RDATA;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            scl_s_q   <= 2'b11;
            sda_s_q   <= 2'b11;
            scl_cnt_q <= '0;
            sda_cnt_q <= '0;
            scl_f_q   <= 1'b1;
            sda_f_q   <= 1'b1;
            scl_p_q   <= 1'b1;
            sda_p_q   <= 1'b1;
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= '0;
            ptr_q     <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            rw_q      <= 1'b0;
        end else begin
            scl_s_q   <= scl_s_d;
            sda_s_q   <= sda_s_d;
            scl_cnt_q <= scl_cnt_d;
            sda_cnt_q <= sda_cnt_d;
            scl_f_q   <= scl_f_d;
            sda_f_q   <= sda_f_d;
            scl_p_q   <= scl_p_d;
            sda_p_q   <= sda_p_d;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ptr_q     <= ptr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            rw_q      <= rw_d;
        end
    end

    assign I2C_SDAT  = sda_oe_q ? 1'b0 : 1'bz;
    assign oREG_ADDR = ptr_q;
    assign oWR_DATA  = wr_data_q;
    assign oWR_EN    = wr_en_q;
    assign oRD_EN    = rd_en_q;
    assign oBUSY     = busy_q;

endmodule

// File: tb/tb_i2c_reg_responder.sv
// Bench for i2c_reg_responder: bit-banged I2C master, strobe logger and a pointer/memory
// reference model of the register target.
module tb_i2c_reg_responder;
    localparam int Q = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl_drv = 1'b1;
    logic m_low = 1'b0;
    wire  sda_bus;
    logic [7:0] reg_addr, wr_data, rd_data;
    logic wr_en, rd_en, busy;

    int checks = 0;
    int errors = 0;
    logic [15:0] wr_log[$];
    logic [7:0]  rd_log[$];
    int dut_low_cnt = 0;
    int busy_cnt = 0;
    logic [7:0] regfile[256];
    bit         written[256];
    logic [7:0] ref_mem[256];
    logic [7:0] ref_ptr;

    always #5 clk = ~clk;

    assign sda_bus = m_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    i2c_reg_responder #(.SLAVE_ADDR(7'h39), .FILTER_LEN(4)) dut (
        .iCLK(clk), .iRST(rst), .I2C_SCLK(scl_drv), .I2C_SDAT(sda_bus),
        .oREG_ADDR(reg_addr), .oWR_DATA(wr_data), .oWR_EN(wr_en), .oRD_EN(rd_en),
        .iRD_DATA(rd_data), .oBUSY(busy)
    );

    // external register file: unwritten locations read as addr ^ 0xA5
    always_comb rd_data = written[reg_addr] ? regfile[reg_addr] : (reg_addr ^ 8'hA5);

    always @(negedge clk) begin
        if (wr_en) begin
            wr_log.push_back({reg_addr, wr_data});
            regfile[reg_addr] = wr_data;
            written[reg_addr] = 1'b1;
        end
        if (rd_en) rd_log.push_back(reg_addr);
        if (sda_bus === 1'b0 && !m_low) dut_low_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        m_low = 1'b0; scl_drv = 1'b1; cyc(2*Q);
        m_low = 1'b1; cyc(2*Q);
        scl_drv = 1'b0;
    endtask

    task automatic bus_rstart();
        cyc(Q); m_low = 1'b0; cyc(Q); scl_drv = 1'b1; cyc(2*Q);
        m_low = 1'b1; cyc(2*Q); scl_drv = 1'b0;
    endtask

    task automatic bus_stop();
        cyc(Q); m_low = 1'b1; cyc(Q); scl_drv = 1'b1; cyc(2*Q);
        m_low = 1'b0; cyc(2*Q);
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        cyc(Q); m_low = ~b;
        if (glitch) begin
            cyc(2); scl_drv = 1'b1; cyc(2); scl_drv = 1'b0; cyc(Q-4);
        end else begin
            cyc(Q);
        end
        scl_drv = 1'b1; cyc(2*Q); scl_drv = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        cyc(Q); m_low = 1'b0; cyc(Q); scl_drv = 1'b1; cyc(Q);
        b = sda_bus;
        cyc(Q); scl_drv = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input int glitch_bit, input logic chk_rel,
                             output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i], glitch_bit == i);
        recv_bit(ack);
        if (chk_rel) begin
            cyc(12);
            checks++;
            if (sda_bus !== 1'b1) begin
                errors++; $display("FAIL ack_release: sda=%b want 1", sda_bus);
            end
        end
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(nack, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1; scl_drv = 1'b1; m_low = 1'b0; cyc(10);
        checks++;
        if ({wr_en, rd_en, busy} !== 3'b000) begin
            errors++; $display("FAIL reset_strobes: got %b want 000", {wr_en, rd_en, busy});
        end
        checks++;
        if ({reg_addr, wr_data} !== 16'h0000) begin
            errors++; $display("FAIL reset_regs: got %h want 0000", {reg_addr, wr_data});
        end
        checks++;
        if (sda_bus !== 1'b1) begin
            errors++; $display("FAIL reset_sda: got %b want 1", sda_bus);
        end
        rst = 1'b0; cyc(20);
    endtask

    task automatic test_write();
        logic a0, a1, a2;
        int bw = wr_log.size();
        bus_start(); send_byte(8'h72, -1, 1'b1, a0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL write_busy: got %b want 1", busy); end
        send_byte(8'h98, -1, 1'b1, a1); send_byte(8'h03, -1, 1'b1, a2); bus_stop();
        checks++;
        if ({a0, a1, a2} !== 3'b000) begin
            errors++; $display("FAIL write_acks: got %b want 000", {a0, a1, a2});
        end
        checks++;
        if (wr_log.size() != bw + 1 || wr_log[bw] !== 16'h9803) begin
            errors++; $display("FAIL write_strobe: got %0d entries first %h want 1 entry 9803",
                               wr_log.size() - bw, wr_log.size() > bw ? wr_log[bw] : 16'hxxxx);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_stop: got %b want 0", busy); end
        checks++;
        if (reg_addr !== 8'h99) begin errors++; $display("FAIL write_ptr: got %h want 99", reg_addr); end
        ref_mem[8'h98] = 8'h03;
    endtask

    task automatic test_mismatch();
        logic a0, a1, a2;
        int bw = wr_log.size(), br = rd_log.size(), bl = dut_low_cnt, bb = busy_cnt;
        bus_start(); send_byte(8'h74, -1, 1'b1, a0); send_byte(8'h98, -1, 1'b1, a1);
        send_byte(8'h03, -1, 1'b1, a2); bus_stop();
        checks++;
        if ({a0, a1, a2} !== 3'b111) begin
            errors++; $display("FAIL mismatch_acks: got %b want 111", {a0, a1, a2});
        end
        checks++;
        if (dut_low_cnt != bl) begin
            errors++; $display("FAIL mismatch_sda: got %0d low cycles want 0", dut_low_cnt - bl);
        end
        checks++;
        if (wr_log.size() != bw || rd_log.size() != br) begin
            errors++; $display("FAIL mismatch_strobes: got %0d/%0d want 0/0",
                               wr_log.size() - bw, rd_log.size() - br);
        end
        checks++;
        if (busy_cnt != bb) begin
            errors++; $display("FAIL mismatch_busy: got %0d busy cycles want 0", busy_cnt - bb);
        end
    endtask

    task automatic test_burst();
        logic a0, a1, a2, a3;
        int bw = wr_log.size();
        bus_start(); send_byte(8'h72, -1, 1'b1, a0); send_byte(8'hFF, -1, 1'b1, a1);
        send_byte(8'h11, -1, 1'b1, a2); send_byte(8'h22, -1, 1'b1, a3); bus_stop();
        checks++;
        if ({a0, a1, a2, a3} !== 4'b0000) begin
            errors++; $display("FAIL burst_acks: got %b want 0000", {a0, a1, a2, a3});
        end
        checks++;
        if (wr_log.size() != bw + 2 || wr_log[bw] !== 16'hFF11 || wr_log[bw+1] !== 16'h0022) begin
            errors++; $display("FAIL burst_strobes: got %0d entries want FF11,0022", wr_log.size() - bw);
        end
        checks++;
        if (reg_addr !== 8'h01) begin errors++; $display("FAIL burst_ptr: got %h want 01", reg_addr); end
        ref_mem[8'hFF] = 8'h11; ref_mem[8'h00] = 8'h22;
    endtask

    task automatic test_read();
        logic a0, a1, a2;
        logic [7:0] d0, d1, e0, e1;
        int br = rd_log.size();
        e0 = ref_mem[8'h41]; e1 = ref_mem[8'h42];
        bus_start(); send_byte(8'h72, -1, 1'b1, a0); send_byte(8'h41, -1, 1'b1, a1);
        bus_rstart(); send_byte(8'h73, -1, 1'b0, a2);
        recv_byte(d0, 1'b0); recv_byte(d1, 1'b1);
        cyc(12);
        checks++;
        if (sda_bus !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL read_nack_release: sda=%b busy=%b want 1 0", sda_bus, busy);
        end
        bus_stop();
        checks++;
        if ({a0, a1, a2} !== 3'b000) begin
            errors++; $display("FAIL read_acks: got %b want 000", {a0, a1, a2});
        end
        checks++;
        if (d0 !== e0 || d1 !== e1) begin
            errors++; $display("FAIL read_data: got %h %h want %h %h", d0, d1, e0, e1);
        end
        checks++;
        if (rd_log.size() != br + 2 || rd_log[br] !== 8'h41 || rd_log[br+1] !== 8'h42) begin
            errors++; $display("FAIL read_strobes: got %0d entries want 41,42", rd_log.size() - br);
        end
        checks++;
        if (reg_addr !== 8'h43) begin errors++; $display("FAIL read_ptr: got %h want 43", reg_addr); end
    endtask

    task automatic test_glitch();
        logic a0, a1, a2;
        int bw = wr_log.size();
        bus_start(); send_byte(8'h72, -1, 1'b1, a0); send_byte(8'h30, 2, 1'b1, a1);
        send_byte(8'h6C, 4, 1'b1, a2); bus_stop();
        checks++;
        if ({a0, a1, a2} !== 3'b000 || wr_log.size() != bw + 1 || wr_log[bw] !== 16'h306C) begin
            errors++; $display("FAIL glitch_decode: acks %b entries %0d want 000 and one 306C",
                               {a0, a1, a2}, wr_log.size() - bw);
        end
        ref_mem[8'h30] = 8'h6C;
    endtask

    task automatic test_stop_mid();
        logic a0, a1;
        int bw = wr_log.size();
        bus_start(); send_byte(8'h72, -1, 1'b1, a0); send_byte(8'h31, -1, 1'b1, a1);
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL stopmid_busy: got %b want 1", busy); end
        bus_stop();
        checks++;
        if (busy !== 1'b0 || wr_log.size() != bw || reg_addr !== 8'h31) begin
            errors++; $display("FAIL stopmid_idle: busy %b strobes %0d ptr %h want 0 0 31",
                               busy, wr_log.size() - bw, reg_addr);
        end
    endtask

    task automatic test_reset_ack();
        logic a0, a1, a2;
        logic [7:0] d;
        int bw;
        d = 8'h72;
        bus_start();
        for (int i = 7; i >= 0; i--) send_bit(d[i], 1'b0);
        m_low = 1'b0;
        cyc(12);
        checks++;
        if (sda_bus !== 1'b0) begin errors++; $display("FAIL rstack_drive: sda=%b want 0", sda_bus); end
        rst = 1'b1;
        cyc(1);
        checks++;
        if (sda_bus !== 1'b1) begin errors++; $display("FAIL rstack_release: sda=%b want 1", sda_bus); end
        checks++;
        if ({reg_addr, wr_data, wr_en, rd_en, busy} !== 19'h0) begin
            errors++; $display("FAIL rstack_outputs: got %h want 0", {reg_addr, wr_data, wr_en, rd_en, busy});
        end
        scl_drv = 1'b1; cyc(10); rst = 1'b0; cyc(20);
        bw = wr_log.size();
        bus_start(); send_byte(8'h72, -1, 1'b1, a0); send_byte(8'h20, -1, 1'b1, a1);
        send_byte(8'h5A, -1, 1'b1, a2); bus_stop();
        checks++;
        if ({a0, a1, a2} !== 3'b000 || wr_log.size() != bw + 1 || wr_log[bw] !== 16'h205A) begin
            errors++; $display("FAIL rstack_after: acks %b entries %0d want 000 and one 205A",
                               {a0, a1, a2}, wr_log.size() - bw);
        end
        ref_mem[8'h20] = 8'h5A;
    endtask

    task automatic test_random();
        logic ack;
        logic [7:0] sub, rsub, d, got;
        logic [15:0] exp_w[$];
        logic [7:0]  exp_r[$];
        int n, nr, bw, br, bad;
        for (int it = 0; it < 4; it++) begin
            sub = 8'($urandom); n = $urandom_range(1, 3);
            bw = wr_log.size(); exp_w.delete(); bad = 0;
            bus_start(); send_byte(8'h72, -1, 1'b1, ack); send_byte(sub, -1, 1'b1, ack);
            ref_ptr = sub;
            for (int k = 0; k < n; k++) begin
                d = 8'($urandom);
                send_byte(d, -1, 1'b1, ack);
                exp_w.push_back({ref_ptr, d});
                ref_mem[ref_ptr] = d;
                ref_ptr = ref_ptr + 8'd1;
            end
            bus_stop();
            checks++;
            if (wr_log.size() != bw + n) bad = 1;
            else for (int k = 0; k < n; k++) if (wr_log[bw+k] !== exp_w[k]) bad = 1;
            if (bad != 0 || reg_addr !== ref_ptr) begin
                errors++; $display("FAIL rand_write[%0d]: entries %0d ptr %h want %0d ptr %h",
                                   it, wr_log.size() - bw, reg_addr, n, ref_ptr);
            end

            rsub = sub + 8'($urandom_range(0, n - 1)); nr = $urandom_range(1, 3);
            br = rd_log.size(); exp_r.delete(); bad = 0;
            bus_start(); send_byte(8'h72, -1, 1'b1, ack); send_byte(rsub, -1, 1'b1, ack);
            bus_rstart(); send_byte(8'h73, -1, 1'b0, ack);
            ref_ptr = rsub;
            for (int k = 0; k < nr; k++) begin
                recv_byte(got, k == nr - 1);
                checks++;
                if (got !== ref_mem[ref_ptr]) begin
                    errors++; $display("FAIL rand_read[%0d.%0d]: got %h want %h at %h",
                                       it, k, got, ref_mem[ref_ptr], ref_ptr);
                end
                exp_r.push_back(ref_ptr);
                ref_ptr = ref_ptr + 8'd1;
            end
            bus_stop();
            checks++;
            if (rd_log.size() != br + nr) bad = 1;
            else for (int k = 0; k < nr; k++) if (rd_log[br+k] !== exp_r[k]) bad = 1;
            if (bad != 0 || reg_addr !== ref_ptr || busy !== 1'b0) begin
                errors++; $display("FAIL rand_rdstrobe[%0d]: entries %0d ptr %h busy %b want %0d ptr %h busy 0",
                                   it, rd_log.size() - br, reg_addr, busy, nr, ref_ptr);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'hA5;
        test_reset();
        test_write();
        test_mismatch();
        test_burst();
        test_read();
        test_glitch();
        test_stop_mid();
        test_reset_ack();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
